fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register of the Antares-R2 datapath.
//  Holds the PC and fetches words over a req/ready instruction-memory port that allows wait states.
//  Presents the registered instruction to decode; opCode feeds control_unit directly.
//  Absorbs hazard stalls and branch/jump redirects; jump targets are computed here.
// PARAMETERS
//  RESET_PC  32'h0000_0000  first fetch address after reset (word aligned)
//  AW        32             PC / memory address width
// PORTS
//  clock          in   1   single system clock; all state updates on rising edge
//  reset          in   1   synchronous, active-high
//  imem_req       out  1   fetch request; imem_addr held stable until imem_ready
//  imem_addr      out  AW  address of the outstanding fetch
//  imem_ready     in   1   response valid this cycle; only meaningful while imem_req=1
//  imem_rdata     in   32  instruction word returned with imem_ready
//  stall          in   1   hazard unit: hold IF/ID contents
//  jump           in   1   control_unit jump for the instruction in IF/ID
//  branch_taken   in   1   EX stage resolved a taken branch
//  branch_target  in   AW  target of the taken branch
//  if_id_valid    out  1   IF/ID holds a real instruction
//  if_id_instr    out  32  IF/ID instruction; forced 32'h0 (NOP) when invalid
//  if_id_pc4      out  AW  PC+4 of the IF/ID instruction
//  opCode         out  6   if_id_instr[31:26], to control_unit
// BEHAVIOUR
//  Reset (reset=1 at edge): state=IDLE, pc=RESET_PC, imem_req=0, if_id_valid=0,
//   if_id_instr=0, if_id_pc4=0, hold buffer=0, pending target=0.
//  imem_req = (state==FETCH || state==DROP). imem_addr = pc.
//  Redirect:
//   redir = branch_taken | (jump & if_id_valid & ~stall).
//   target = branch_taken ? branch_target : {if_id_pc4[AW-1:28], if_id_instr[25:0], 2'b00}.
//   branch_taken has priority over jump. Any redirect clears IF/ID (valid=0, instr=0) the same edge.
//  States:
//   IDLE:  -> FETCH unconditionally. The first request issues in the cycle after reset deasserts.
//   FETCH: ready & ~redir & ~stall: IF/ID <= {1, rdata, pc+4}; pc <= pc+4; stay.
//          Gives 1 instr/cycle with a zero-wait memory.
//          ready & ~redir & stall: buffer <= rdata; pc <= pc+4; -> HOLD; IF/ID unchanged.
//          ~ready & ~redir: stall ? IF/ID unchanged : IF/ID <= bubble (valid 0, instr 0).
//          redir & ready: response discarded; pc <= target; stay FETCH.
//          redir & ~ready: pend <= target; -> DROP. pc and imem_addr stay on the old address.
//   HOLD:  imem_req=0. ~stall & ~redir: IF/ID <= {1, buffer, pc}; -> FETCH.
//          pc already equals fetched_addr+4 here.
//          redir: buffer discarded; pc <= target; -> FETCH.
//   DROP:  wait for the in-flight response. ready: discard it; pc <= pend; -> FETCH.
//          redir while in DROP: pend <= new target (latest wins).
//  Address arithmetic: pc+4 wraps modulo 2^AW. The low 2 bits of targets are passed through unchecked.
//  Reset mid-operation: an outstanding request is abandoned with no handshake.
//   The memory must tolerate imem_req dropping before ready.
//  At most one fetch is outstanding. An imem_ready seen while imem_req=0 is ignored.
// TESTING
//  T1 reset, zero-wait mem (mem[a]=a|32'hA000_0000): if_id_pc4 = 4,8,12,... on consecutive cycles;
//     first valid 2 cycles after reset falls.
//  T2 mem with 2 wait states: imem_addr held 3 cycles; if_id_valid=0 during the waits;
//     if_id_instr=0 while invalid.
//  T3 stall=1 for 3 cycles while a response arrives: IF/ID frozen, imem_req=0 in HOLD;
//     on release the buffered word reaches IF/ID with correct pc4, no word lost or duplicated.
//  T4 IF/ID holds J 0x0000010 at pc4=0x0000_0024, jump=1: next imem_addr=0x0000_0040, IF/ID invalid 1 cycle.
//  T5 branch_taken=1 (target 0x100) same cycle as jump=1, request in flight with 2 waits:
//     DROP, old word discarded, next request addr=0x100.
//  T6 reset asserted during DROP and during HOLD: next cycle all outputs at reset values;
//     fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Antares-R2 instruction-fetch stage with IF/ID pipeline
//                register. Owns the PC, issues fetches over a req/ready
//                instruction-memory port with wait states, absorbs hazard
//                stalls and branch/jump redirects, and computes jump targets.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter int          AW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clock,
  input  logic          reset,
  // instruction memory port
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ready,
  input  logic [31:0]   imem_rdata,
  // pipeline control
  input  logic          stall,
  input  logic          jump,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_target,
  // IF/ID register
  output logic          if_id_valid,
  output logic [31:0]   if_id_instr,
  output logic [AW-1:0] if_id_pc4,
  output logic [5:0]    opCode
);

  // IDLE  : one-cycle gap after reset before the first request
  // FETCH : request outstanding at r_pc
  // HOLD  : a fetched word is parked in the buffer while decode is stalled
  // DROP  : a redirect arrived mid-fetch; swallow the stale response
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } state_t;

  localparam logic [AW-1:0] C_WORD_BYTES = {{(AW-3){1'b0}}, 3'd4};

  state_t        r_state, w_state_n;
  logic [AW-1:0] r_pc,    w_pc_n;
  logic [31:0]   r_buf,   w_buf_n;
  logic [AW-1:0] r_pend,  w_pend_n;
  logic          r_valid, w_valid_n;
  logic [31:0]   r_instr, w_instr_n;
  logic [AW-1:0] r_pc4,   w_pc4_n;

  logic          w_redir;
  logic [AW-1:0] w_target;
  logic [AW-1:0] w_pc_inc;

  // Redirect decode: a taken branch always wins; a jump only counts when the
  // jump instruction really sits in IF/ID and decode is not stalled.
  always_comb begin
    w_redir  = branch_taken | (jump & r_valid & ~stall);
    w_target = branch_taken ? branch_target
                            : {r_pc4[AW-1:28], r_instr[25:0], 2'b00};
    w_pc_inc = r_pc + C_WORD_BYTES;
  end

  // Next-state, next-PC and next IF/ID contents.
  always_comb begin
    w_state_n = r_state;
    w_pc_n    = r_pc;
    w_buf_n   = r_buf;
    w_pend_n  = r_pend;
    w_valid_n = r_valid;
    w_instr_n = r_instr;
    w_pc4_n   = r_pc4;

    case (r_state)
      S_IDLE: begin
        w_state_n = S_FETCH;
        if (w_redir) begin
          w_pc_n = w_target;
        end
      end

      S_FETCH: begin
        if (w_redir) begin
          if (imem_ready) begin
            // response is stale; restart immediately at the target
            w_pc_n = w_target;
          end else begin
            // cannot retract the request; remember where to go afterwards
            w_pend_n  = w_target;
            w_state_n = S_DROP;
          end
        end else if (imem_ready) begin
          w_pc_n = w_pc_inc;
          if (stall) begin
            w_buf_n   = imem_rdata;
            w_state_n = S_HOLD;
          end else begin
            w_valid_n = 1'b1;
            w_instr_n = imem_rdata;
            w_pc4_n   = w_pc_inc;
          end
        end else if (!stall) begin
          // memory wait state: feed a bubble to decode
          w_valid_n = 1'b0;
          w_instr_n = 32'h0;
        end
      end

      S_HOLD: begin
        if (w_redir) begin
          w_pc_n    = w_target;
          w_state_n = S_FETCH;
        end else if (!stall) begin
          // r_pc already advanced past the buffered word, so it is its pc4
          w_valid_n = 1'b1;
          w_instr_n = r_buf;
          w_pc4_n   = r_pc;
          w_state_n = S_FETCH;
        end
      end

      S_DROP: begin
        if (w_redir) begin
          w_pend_n = w_target;
        end
        if (imem_ready) begin
          w_pc_n    = w_redir ? w_target : r_pend;
          w_state_n = S_FETCH;
        end
      end

      default: begin
        w_state_n = S_IDLE;
      end
    endcase

    // every redirect flushes whatever is in IF/ID
    if (w_redir) begin
      w_valid_n = 1'b0;
      w_instr_n = 32'h0;
    end
  end

  // State and pipeline register update with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_buf   <= 32'h0;
      r_pend  <= '0;
      r_valid <= 1'b0;
      r_instr <= 32'h0;
      r_pc4   <= '0;
    end else begin
      r_state <= w_state_n;
      r_pc    <= w_pc_n;
      r_buf   <= w_buf_n;
      r_pend  <= w_pend_n;
      r_valid <= w_valid_n;
      r_instr <= w_instr_n;
      r_pc4   <= w_pc4_n;
    end
  end

  // Output mapping; the request stays up through DROP so the handshake completes.
  always_comb begin
    imem_req    = (r_state == S_FETCH) || (r_state == S_DROP);
    imem_addr   = r_pc;
    if_id_valid = r_valid;
    if_id_instr = r_instr;
    if_id_pc4   = r_pc4;
    opCode      = r_instr[31:26];
  end

endmodule
`default_nettype wire
